// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: records retired register writes into a FWFT FIFO
// and drains them over valid/ready; drops (and counts) captures when full.
module wb_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      debug_wb_pc,
    input  logic [3:0]       debug_wb_rf_wen,
    input  logic [4:0]       debug_wb_rf_wnum,
    input  logic [31:0]      debug_wb_rf_wdata,
    input  logic             trace_en,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [3:0]       out_wen,
    output logic [4:0]       out_wnum,
    output logic [31:0]      out_wdata,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic [15:0]      overflow_cnt
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [72:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      ovf_q, ovf_d;

    logic        cap, push, pop;
    logic [72:0] entry_d;
    logic [72:0] head;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign overflow_cnt = ovf_q;
    assign out_valid = !empty;

    always_comb begin
        cap     = trace_en && (debug_wb_rf_wen != '0) && (debug_wb_rf_wnum != '0);
        pop     = out_valid && out_ready && !clr;
        push    = cap && (!full || (out_valid && out_ready)) && !clr;
        entry_d = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
            else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
            if (cap && full && !pop && (ovf_q != '1)) ovf_d = ovf_q + 16'd1;
        end
    end

    always_comb begin
        head = empty ? '0 : mem_q[rd_ptr_q];
        out_pc    = head[72:41];
        out_wen   = head[40:37];
        out_wnum  = head[36:32];
        out_wdata = head[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; only occupied slots are ever presented.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= entry_d;
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_wb_trace_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [3:0]  wen = '0;
    logic [4:0]  wnum = '0;
    logic [31:0] wdata = '0;
    logic        trace_en = 1'b0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;

    logic        out_valid;
    logic [31:0] out_pc;
    logic [3:0]  out_wen;
    logic [4:0]  out_wnum;
    logic [31:0] out_wdata;
    logic [PTR_W:0] count;
    logic        full;
    logic        empty;
    logic [15:0] overflow_cnt;

    wb_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .debug_wb_pc(pc), .debug_wb_rf_wen(wen),
        .debug_wb_rf_wnum(wnum), .debug_wb_rf_wdata(wdata),
        .trace_en(trace_en), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
        .count(count), .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [72:0] mq[$];
    int unsigned m_ovf = 0;
    logic [72:0] plog[$];

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [72:0] exp_head;
        exp_head = (mq.size() != 0) ? mq[0] : '0;
        check("count", 73'(count), 73'(mq.size()));
        check("empty", 73'(empty), 73'(mq.size() == 0));
        check("full", 73'(full), 73'(mq.size() == DEPTH));
        check("out_valid", 73'(out_valid), 73'(mq.size() != 0));
        check("overflow_cnt", 73'(overflow_cnt), 73'(m_ovf));
        check("head", {out_pc, out_wen, out_wnum, out_wdata}, exp_head);
    endtask

    // One clock: model decides from pre-edge state, then DUT is compared after the edge.
    task automatic tick();
        logic [72:0] e;
        bit mv, mpop, mcap, mfull;
        e     = {pc, wen, wnum, wdata};
        mv    = (mq.size() != 0);
        mpop  = mv && out_ready;
        mcap  = trace_en && (wen != 0) && (wnum != 0);
        mfull = (mq.size() == DEPTH);
        if (!rst && !clr && out_valid && out_ready)
            plog.push_back({out_pc, out_wen, out_wnum, out_wdata});
        @(posedge clk);
        #1;
        if (rst || clr) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (mcap) begin
                if (!mfull || mpop) mq.push_back(e);
                else if (m_ovf < 32'hFFFF) m_ovf++;
            end
        end
        compare_all();
    endtask

    task automatic set_write(input logic [31:0] p, input logic [3:0] w,
                             input logic [4:0] n, input logic [31:0] d);
        pc = p; wen = w; wnum = n; wdata = d;
    endtask

    task automatic idle_inputs();
        set_write('0, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] got_pc;
        int unsigned nlog;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", 73'(count), 73'd0);
        check("rst_empty", 73'(empty), 73'd1);
        check("rst_ovf", 73'(overflow_cnt), 73'd0);

        // Single write
        trace_en = 1'b1;
        set_write(32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678);
        tick();
        idle_inputs();
        check("single_valid", 73'(out_valid), 73'd1);
        check("single_count", 73'(count), 73'd1);
        check("single_fields", {out_pc, out_wen, out_wnum, out_wdata},
              {32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drain_empty", 73'(empty), 73'd1);

        // Filtering
        set_write(32'h200, 4'hF, 5'd0, 32'hAAAA_AAAA);
        tick();
        set_write(32'h204, 4'h0, 5'd3, 32'hBBBB_BBBB);
        tick();
        trace_en = 1'b0;
        set_write(32'h208, 4'hF, 5'd3, 32'hCCCC_CCCC);
        tick();
        trace_en = 1'b1;
        idle_inputs();
        check("filter_count", 73'(count), 73'd0);
        check("filter_ovf", 73'(overflow_cnt), 73'd0);

        // Fill and overflow
        out_ready = 1'b0;
        for (int i = 0; i < 21; i++) begin
            set_write(32'h100 + 32'(4 * i), 4'hF, 5'd1 + 5'(i % 31), 32'(i));
            tick();
        end
        idle_inputs();
        check("fill_full", 73'(full), 73'd1);
        check("fill_count", 73'(count), 73'd16);
        check("fill_ovf", 73'(overflow_cnt), 73'd5);

        // Full with simultaneous pop
        plog.delete();
        out_ready = 1'b1;
        set_write(32'h999, 4'h3, 5'd9, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        check("fullpop_count", 73'(count), 73'd16);
        check("fullpop_ovf", 73'(overflow_cnt), 73'd5);
        for (int i = 0; i < 16; i++) tick();
        nlog = plog.size();
        check("drain_len", 73'(nlog), 73'd17);
        for (int i = 0; i < 17; i++) begin
            got_pc = (i < int'(nlog)) ? plog[i][72:41] : 32'hFFFF_FFFF;
            check("drain_pc", 73'(got_pc), (i < 16) ? 73'(32'h100 + 32'(4 * i)) : 73'(32'h999));
        end

        // Wrap-around streaming
        rst = 1'b1; tick(); rst = 1'b0;
        plog.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_write(32'h4000 + 32'(4 * i), 4'hF, 5'd5, 32'(i));
            tick();
            if (count > 1) check("stream_count_le1", 73'(count), 73'd1);
        end
        idle_inputs();
        tick();
        check("stream_len", 73'(plog.size()), 73'd100);
        for (int i = 0; i < 100; i++) begin
            if (i < plog.size()) check("stream_data", 73'(plog[i][31:0]), 73'(i));
        end
        check("stream_ovf", 73'(overflow_cnt), 73'd0);

        // Clear priority
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_write(32'h500 + 32'(4 * i), 4'h1, 5'd2, 32'(i + 7));
            tick();
        end
        clr = 1'b1;
        out_ready = 1'b1;
        set_write(32'h600, 4'hF, 5'd4, 32'h1);
        tick();
        clr = 1'b0;
        idle_inputs();
        check("clr_count", 73'(count), 73'd0);
        check("clr_empty", 73'(empty), 73'd1);
        check("clr_ovf", 73'(overflow_cnt), 73'd0);

        // Reset priority with overflow_cnt = 7
        out_ready = 1'b0;
        for (int i = 0; i < 23; i++) begin
            set_write(32'h700 + 32'(4 * i), 4'hF, 5'd6, 32'(i));
            tick();
        end
        check("pre_rst_ovf", 73'(overflow_cnt), 73'd7);
        rst = 1'b1;
        out_ready = 1'b1;
        set_write(32'h800, 4'hF, 5'd6, 32'h2);
        tick();
        rst = 1'b0;
        idle_inputs();
        check("rst_mid_count", 73'(count), 73'd0);
        check("rst_mid_empty", 73'(empty), 73'd1);
        check("rst_mid_ovf", 73'(overflow_cnt), 73'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            trace_en  = ($urandom_range(0, 9) < 8);
            wen       = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            wnum      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            pc        = $urandom;
            wdata     = $urandom;
            out_ready = ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 3 : 8));
            clr       = ($urandom_range(0, 99) == 0);
            tick();
        end
        clr = 1'b0;
        trace_en = 1'b0;
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
